// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// UART_RX_BREAK_DET_EN adds the BREAK_WAIT state used by break detection.
package uart_pkg;

    localparam int DEFAULT_PRESCALE = 8;
    localparam int MIN_PRESCALE     = 6;
    localparam int MIN_DATA_LEN     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
`ifdef UART_RX_BREAK_DET_EN
        , ST_BREAK_WAIT
`endif
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority voter around the middle of each oversampled bit.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit
);

    logic [PRESCALE_W-1:0] half;
    logic [2:0]            samples;

    assign half = prescale >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples <= '0;
        end else begin
            if (edge_cnt == half - PRESCALE_W'(1)) samples[0] <= rx_in;
            if (edge_cnt == half)                  samples[1] <= rx_in;
            if (edge_cnt == half + PRESCALE_W'(1)) samples[2] <= rx_in;
        end
    end

    assign sampled_bit = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                         (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, oversampling counters, deserialiser, parity/stop checks.
// UART_RX_BREAK_DET_EN enables the break_det port and the BREAK_WAIT state.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2_EN,
    input  logic [3:0]            DATA_LEN,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
`ifdef UART_RX_BREAK_DET_EN
    , output logic                break_det
`endif
);

    rx_state_e             state, state_nxt;
    logic [PRESCALE_W-1:0] edge_cnt, lat_pre, half;
    logic [3:0]            bit_cnt, lat_len;
    logic                  lat_par_en, lat_par_typ, lat_stop2;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  sampled, counting, start_det, last_edge, sample_pt;
    logic                  final_stop, frame_end, good, brk;
    logic                  par_err_d, stp_err_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                  zero_run, zero_run_d, stop_low, stop_low_d;
`endif

    assign half = lat_pre >> 1;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .rx_in       (RX_IN),
        .edge_cnt    (edge_cnt),
        .prescale    (lat_pre),
        .sampled_bit (sampled)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!RX_IN) state_nxt = ST_START;
            ST_START:  if (last_edge) state_nxt = sampled ? ST_IDLE : ST_DATA;
            ST_DATA:   if (last_edge && bit_cnt == lat_len - 4'd1)
                           state_nxt = lat_par_en ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (last_edge) state_nxt = ST_STOP1;
            ST_STOP1:  if (last_edge) state_nxt = lat_stop2 ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  if (last_edge) state_nxt = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
            ST_BREAK_WAIT: if (RX_IN) state_nxt = ST_IDLE;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
`ifdef UART_RX_BREAK_DET_EN
        if (frame_end && brk) state_nxt = ST_BREAK_WAIT;
`endif
    end

    // Error flags are formed as next-values so the frame-end decision also sees
    // a sample point that coincides with the last edge (Prescale = 6).
    always_comb begin
        busy       = (state != ST_IDLE);
        counting   = busy;
        start_det  = (state == ST_IDLE) && !RX_IN;
        last_edge  = (edge_cnt == lat_pre - PRESCALE_W'(1));
        sample_pt  = (edge_cnt == half + PRESCALE_W'(2));
        final_stop = (state == ST_STOP2) || (state == ST_STOP1 && !lat_stop2);
        frame_end  = final_stop && last_edge;
        par_err_d  = par_err;
        stp_err_d  = stp_err;
        brk        = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        if (state == ST_BREAK_WAIT) counting = 1'b0;
        zero_run_d = zero_run;
        stop_low_d = stop_low;
`endif
        if (start_det) begin
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_run_d = 1'b1;
            stop_low_d = 1'b0;
`endif
        end else if (sample_pt) begin
            if (state == ST_PARITY) par_err_d = sampled ^ (^shreg) ^ lat_par_typ;
`ifdef UART_RX_BREAK_DET_EN
            if (state inside {ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2} && sampled)
                zero_run_d = 1'b0;
            // An all-zero frame is a break, so a low stop bit is only an error otherwise.
            if (state == ST_STOP1 || state == ST_STOP2) begin
                if (final_stop) stp_err_d = (stop_low || !sampled) && !(zero_run && !sampled);
                else            stop_low_d = !sampled;
            end
`else
            if ((state == ST_STOP1 || state == ST_STOP2) && !sampled) stp_err_d = 1'b1;
`endif
        end
`ifdef UART_RX_BREAK_DET_EN
        brk = zero_run_d;
`endif
        good = !par_err_d && !stp_err_d && !brk;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            lat_pre     <= PRESCALE_W'(DEFAULT_PRESCALE);
            lat_len     <= 4'(DATA_WIDTH);
            lat_par_en  <= 1'b0;
            lat_par_typ <= 1'b0;
            lat_stop2   <= 1'b0;
            shreg       <= '0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_run    <= 1'b0;
            stop_low    <= 1'b0;
            break_det   <= 1'b0;
`endif
        end else begin
            par_err    <= par_err_d;
            stp_err    <= stp_err_d;
            data_valid <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_run   <= zero_run_d;
            stop_low   <= stop_low_d;
            break_det  <= 1'b0;
`endif
            if (start_det) begin
                lat_pre     <= (!Prescale[0] && Prescale >= PRESCALE_W'(MIN_PRESCALE)) ?
                               Prescale : PRESCALE_W'(DEFAULT_PRESCALE);
                lat_len     <= (DATA_LEN >= 4'(MIN_DATA_LEN) && DATA_LEN <= 4'(DATA_WIDTH)) ?
                               DATA_LEN : 4'(DATA_WIDTH);
                lat_par_en  <= PAR_EN;
                lat_par_typ <= PAR_TYP;
                lat_stop2   <= STOP2_EN;
                edge_cnt    <= PRESCALE_W'(1);
                bit_cnt     <= '0;
                shreg       <= '0;
            end else if (!counting || last_edge) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
            if (state == ST_DATA && sample_pt)
                shreg <= shreg | (DATA_WIDTH'(sampled) << bit_cnt);
            if (state == ST_DATA && last_edge)
                bit_cnt <= bit_cnt + 4'd1;
            if (frame_end) begin
                data_valid <= good;
                if (good) P_DATA <= shreg;
`ifdef UART_RX_BREAK_DET_EN
                break_det <= brk;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed table, hand sequences and random frames.
module tb_uart_rx_ctrl;

    localparam int DW = 9;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2_EN = 1'b0;
    logic [3:0]    DATA_LEN = 4'd8;
    logic [5:0]    Prescale = 6'd8;
    logic [DW-1:0] P_DATA;
    logic          data_valid, par_err, stp_err, busy;
`ifdef UART_RX_BREAK_DET_EN
    logic          break_det;
`endif

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2_EN   (STOP2_EN),
        .DATA_LEN   (DATA_LEN),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det (break_det)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned cfg_pre, cfg_len, pre, len;
        bit          par_en, typ, stop2;
        logic [8:0]  data;
        bit          flip_par;
        bit [1:0]    stop_low;
        bit          exp_valid, exp_par, exp_stp;
        logic [8:0]  exp_pdata;
    } vec_t;

    int total = 0, bad = 0;
    int cyc = 0, dv_cnt = 0, dv_last = 0, dv_prev = 0, busy_cnt = 0, bk_cnt = 0;
    logic [8:0] exp_pd;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cnt++;
            dv_prev = dv_last;
            dv_last = cyc;
        end
        if (busy) busy_cnt++;
`ifdef UART_RX_BREAK_DET_EN
        if (break_det) bk_cnt++;
`endif
    end

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic vec_t mk(input int unsigned cp, input int unsigned cl, input int unsigned p,
                                input int unsigned l, input bit pe, input bit pt, input bit s2,
                                input logic [8:0] d, input bit fp, input bit [1:0] sl,
                                input bit ev, input bit ep, input bit es, input logic [8:0] epd);
        vec_t v;
        v.cfg_pre = cp; v.cfg_len = cl; v.pre = p; v.len = l;
        v.par_en = pe; v.typ = pt; v.stop2 = s2; v.data = d;
        v.flip_par = fp; v.stop_low = sl;
        v.exp_valid = ev; v.exp_par = ep; v.exp_stp = es; v.exp_pdata = epd;
        return v;
    endfunction

    // Reference: the parity bit makes the count of ones even (or odd); the receiver
    // recounts ones over data plus received parity bit.
    function automatic vec_t model(input vec_t v, input logic [8:0] prev);
        vec_t r = v;
        int   ones = $countones(v.data);
        bit   rx_par = ((ones % 2) != 0) ^ v.typ ^ v.flip_par;
        r.exp_par   = v.par_en && (((ones + int'(rx_par)) % 2) != (v.typ ? 1 : 0));
        r.exp_stp   = v.stop_low[0] || (v.stop2 && v.stop_low[1]);
        r.exp_valid = !r.exp_par && !r.exp_stp;
        r.exp_pdata = r.exp_valid ? v.data : prev;
        return r;
    endfunction

    // Called on a negedge; returns on the negedge ending the final stop bit.
    task automatic drive_frame(input vec_t v, input bit scramble, output int start_cyc);
        bit q[$];
        int ones = 0;
        Prescale = 6'(v.cfg_pre);
        DATA_LEN = 4'(v.cfg_len);
        PAR_EN   = v.par_en;
        PAR_TYP  = v.typ;
        STOP2_EN = v.stop2;
        q.push_back(1'b0);
        for (int i = 0; i < int'(v.len); i++) begin
            q.push_back(v.data[i]);
            ones += int'(v.data[i]);
        end
        if (v.par_en) q.push_back(((ones % 2) != 0) ^ v.typ ^ v.flip_par);
        q.push_back(!v.stop_low[0]);
        if (v.stop2) q.push_back(!v.stop_low[1]);
        start_cyc = cyc;
        foreach (q[i]) begin
            RX_IN = q[i];
            repeat (v.pre) @(negedge CLK);
            if (scramble && i == 0) begin
                Prescale = 6'd16;
                DATA_LEN = 4'd5;
                PAR_EN   = !v.par_en;
                STOP2_EN = !v.stop2;
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit scramble);
        int s, dv0, b0, n;
        dv0 = dv_cnt;
        b0  = busy_cnt;
        n   = (1 + int'(v.len) + int'(v.par_en) + 1 + int'(v.stop2)) * int'(v.pre);
        drive_frame(v, scramble, s);
        @(negedge CLK);
        check({tag, "_dv_count"}, dv_cnt - dv0, int'(v.exp_valid));
        if (v.exp_valid) check_range({tag, "_latency"}, dv_last - s, n - 1, n + 1);
        check({tag, "_p_data"}, int'(P_DATA), int'(v.exp_pdata));
        check({tag, "_par_err"}, int'(par_err), int'(v.exp_par));
        check({tag, "_stp_err"}, int'(stp_err), int'(v.exp_stp));
        check({tag, "_busy_len"}, busy_cnt - b0, n - 1);
        check({tag, "_busy_end"}, int'(busy), 0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t va, vb;
        int   s, dv0, k;

        //           cpre clen pre len pe typ s2 data    flip stop   ev ep es pdata
        tbl[0] = mk(8,  8,  8,  8, 0, 0, 0, 9'h0A5, 0, 2'b00, 1, 0, 0, 9'h0A5);
        tbl[1] = mk(16, 7,  16, 7, 1, 0, 1, 9'h03C, 1, 2'b00, 0, 1, 0, 9'h0A5);
        tbl[2] = mk(8,  9,  8,  9, 0, 0, 0, 9'h1FF, 0, 2'b01, 0, 0, 1, 9'h0A5);
        tbl[3] = mk(8,  9,  8,  9, 0, 0, 0, 9'h055, 0, 2'b00, 1, 0, 0, 9'h055);
        tbl[4] = mk(6,  5,  6,  5, 1, 1, 0, 9'h015, 0, 2'b00, 1, 0, 0, 9'h015);
        tbl[5] = mk(7,  8,  8,  8, 0, 0, 0, 9'h03C, 0, 2'b00, 1, 0, 0, 9'h03C);
        tbl[6] = mk(10, 3,  10, 9, 1, 0, 0, 9'h1C3, 0, 2'b00, 1, 0, 0, 9'h1C3);
        tbl[7] = mk(12, 8,  12, 8, 1, 0, 1, 9'h081, 0, 2'b10, 0, 0, 1, 9'h1C3);
        tbl[8] = mk(8,  6,  8,  6, 1, 1, 0, 9'h02A, 1, 2'b00, 0, 1, 0, 9'h1C3);
        tbl[9] = mk(8,  8,  8,  8, 1, 1, 0, 9'h000, 0, 2'b01, 0, 0, 1, 9'h1C3);

        repeat (3) @(negedge CLK);
        check("reset_p_data", int'(P_DATA), 0);
        check("reset_data_valid", int'(data_valid), 0);
        check("reset_par_err", int'(par_err), 0);
        check("reset_stp_err", int'(stp_err), 0);
        check("reset_busy", int'(busy), 0);
`ifdef UART_RX_BREAK_DET_EN
        check("reset_break_det", int'(break_det), 0);
`endif
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i], 1'b0);

        run_vec("cfg_change", mk(8, 8, 8, 8, 0, 0, 0, 9'h05A, 0, 2'b00, 1, 0, 0, 9'h05A), 1'b1);

        va = mk(8, 8, 8, 8, 1, 1, 0, 9'h000, 0, 2'b00, 1, 0, 0, 9'h000);
        vb = mk(8, 8, 8, 8, 1, 1, 0, 9'h0FF, 0, 2'b00, 1, 0, 0, 9'h0FF);
        dv0 = dv_cnt;
        drive_frame(va, 1'b0, s);
        drive_frame(vb, 1'b0, s);
        @(negedge CLK);
        check("b2b_dv_count", dv_cnt - dv0, 2);
        check("b2b_spacing", dv_last - dv_prev, 88);
        check("b2b_p_data", int'(P_DATA), 'h0FF);
        repeat (2) @(negedge CLK);

        dv0 = dv_cnt;
        Prescale = 6'd16;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        check("glitch_busy_rise", int'(busy), 1);
        RX_IN = 1'b1;
        k = 0;
        while (busy && k < 40) begin
            @(negedge CLK);
            k++;
        end
        check_range("glitch_busy_drop", k + 2, 1, 17);
        check("glitch_dv_count", dv_cnt - dv0, 0);
        check("glitch_par_err", int'(par_err), 0);
        check("glitch_stp_err", int'(stp_err), 0);
        repeat (2) @(negedge CLK);

        exp_pd = 9'h0FF;
        for (int i = 0; i < 24; i++) begin
            vec_t v;
            int unsigned pre, len;
            bit pe, s2;
            bit [1:0] sl;
            pre = 6 + 2 * $urandom_range(0, 5);
            len = $urandom_range(5, 9);
            pe  = 1'($urandom_range(0, 1));
            s2  = 1'($urandom_range(0, 1));
            sl  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (!s2) sl[1] = 1'b0;
            v = mk(pre, len, pre, len, pe, 1'($urandom_range(0, 1)), s2,
                   9'($urandom_range(1, (1 << len) - 1)),
                   pe && ($urandom_range(0, 3) == 0), sl, 0, 0, 0, 9'h000);
            v = model(v, exp_pd);
            run_vec($sformatf("rnd%0d", i), v, 1'b0);
            exp_pd = v.exp_pdata;
        end

        Prescale = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (24) @(negedge CLK);
        check("rst_mid_busy", int'(busy), 1);
        RST = 1'b0;
        #1;
        check("rst_mid_p_data", int'(P_DATA), 0);
        check("rst_mid_data_valid", int'(data_valid), 0);
        check("rst_mid_par_err", int'(par_err), 0);
        check("rst_mid_stp_err", int'(stp_err), 0);
        check("rst_mid_busy_low", int'(busy), 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        run_vec("post_reset", mk(8, 8, 8, 8, 0, 0, 0, 9'h0C3, 0, 2'b00, 1, 0, 0, 9'h0C3), 1'b0);

`ifdef UART_RX_BREAK_DET_EN
        begin
            int bk0 = bk_cnt;
            dv0 = dv_cnt;
            Prescale = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2_EN = 1'b0;
            RX_IN = 1'b0;
            repeat (240) @(negedge CLK);
            check("break_pulses", bk_cnt - bk0, 1);
            check("break_stp_err", int'(stp_err), 0);
            check("break_dv_count", dv_cnt - dv0, 0);
            check("break_busy_wait", int'(busy), 1);
            RX_IN = 1'b1;
            repeat (3) @(negedge CLK);
            check("break_busy_idle", int'(busy), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Parametrised UART receive controller for the RX path of the UART subsystem. It combines the frame state machine, the oversampling edge/bit counters and a majority-vote bit sampler, and deserialises frames of 5 to 9 data bits. Parity is optional and selectable as even or odd; the frame has one or two stop bits. It delivers parallel data with a one-cycle `data_valid` pulse and registered parity and framing error flags to the register file/SYS controller.

## Interface
- `DATA_WIDTH`, 8, maximum data bits per frame and width of `P_DATA` (5..9).
- `PRESCALE_W`, 6, width of `Prescale` and of the edge counter.
- `CLK` input 1: receiver oversampling clock.
- `RST` input 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `RX_IN` input 1: serial line, idle high, already synchronised to `CLK`.
- `PAR_EN` input 1: parity bit present.
- `PAR_TYP` input 1: 0 = even, 1 = odd.
- `STOP2_EN` input 1: two stop bits.
- `DATA_LEN` input 4: data bits per frame; legal range 5..`DATA_WIDTH`.
- `Prescale` input `PRESCALE_W`: oversampling ratio; legal values are even and ≥ 6.
- `P_DATA` output `DATA_WIDTH`: received data, LSB-aligned, unused MSBs 0.
- `data_valid` output 1: one-cycle pulse, frame good.
- `par_err` output 1: parity mismatch in the last frame.
- `stp_err` output 1: a stop bit was sampled low in the last frame.
- `busy` output 1: high in any state other than IDLE.
- `break_det` output 1: one-cycle pulse; present only with `UART_RX_BREAK_DET_EN`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, and BREAK_WAIT (macro only).
- `edge_cnt` counts 0..`Prescale`-1 within each bit. `bit_cnt` counts data bits.
- Sampling: `RX_IN` is captured at edges `Prescale`/2-1, `Prescale`/2 and `Prescale`/2+1. The sampled bit is the 2-of-3 majority, valid from edge `Prescale`/2+2.
- IDLE: when `RX_IN`=0, latch `PAR_EN`, `PAR_TYP`, `STOP2_EN`, `DATA_LEN` and `Prescale`, clear `par_err`/`stp_err`, set `edge_cnt`=1, and go to START.
  - Config changes mid-frame are ignored.
  - An illegal latched `Prescale` is replaced by 8.
  - An illegal latched `DATA_LEN` is replaced by `DATA_WIDTH`.
- START: at the last edge, a sampled 0 goes to DATA. A sampled 1 is a glitch: return to IDLE with no flags and no pulse.
- DATA: bits are shifted in LSB first. After bit `DATA_LEN`-1, go to PARITY if `PAR_EN`, else STOP1.
- PARITY: `par_err` = received bit XOR (XOR of the data bits) XOR `PAR_TYP`. Next state is STOP1.
- STOP1/STOP2: a sampled 0 sets `stp_err`. STOP1 goes to STOP2 if `STOP2_EN`, else the frame ends. The frame always runs to its full length; there is no early abort on an error.
- Frame end, at the last edge of the final stop bit:
  - `P_DATA` is updated only if there is no error.
  - `data_valid` = !`par_err` && !`stp_err`.
  - Next state is IDLE.
- `P_DATA` holds its value until the next good frame.
- Back-to-back frames: if `RX_IN`=0 in the first IDLE cycle, START is entered immediately.

## Timing
- Reset: state IDLE, counters 0. `P_DATA`, `data_valid`, `par_err`, `stp_err`, `busy` and `break_det` are all 0.
- Reset mid-frame aborts the frame silently.
- `data_valid` and `break_det` are registered. They are high in the single cycle after the last edge of the final stop bit.
- Frame latency from the falling edge of the start bit to `data_valid` = (1 + `DATA_LEN` + `PAR_EN` + 1 + `STOP2_EN`) × `Prescale` cycles, ±1.
- `par_err` and `stp_err` become valid at the sample point of their bit. They are held until the next start detection.
- `busy` rises the cycle after the start edge and falls with the IDLE transition.

## Configuration
- `UART_RX_BREAK_DET_EN` defined: a frame whose data, parity and stop bits are all 0 pulses `break_det`, not `stp_err`/`data_valid`. The FSM then waits in BREAK_WAIT until a sampled `RX_IN`=1 and only then returns to IDLE.
- `UART_RX_BREAK_DET_EN` undefined: no `break_det` port and no BREAK_WAIT state. Such a frame raises `stp_err`, and a line that stays low restarts a frame from IDLE.

## Structure
- Shared package `uart_pkg`: state encodings, the default prescale (8), and the minimum legal prescale (6) and minimum legal data length (5).
- One sub-module, `uart_rx_sampler`: the three-point majority voter, driven by `edge_cnt` and the latched `Prescale`.
- Counters, the shift register, parity and the FSM live in the top level.

## Test plan
- 8N1, `Prescale`=8, byte 0xA5 -> `P_DATA`=0xA5 and one `data_valid` pulse 80±1 cycles after the start edge; no errors.
- 7E2, `Prescale`=16, 0x3C with a corrupted parity bit -> `par_err`=1, no `data_valid`, `P_DATA` keeps its previous value, and `busy` stays high for the full 11 bits.
- Start pulse low for 2 cycles at `Prescale`=16 -> return to IDLE, no flags, `busy` drops within `Prescale` cycles.
- Stop bit driven low on 9N1 with `DATA_WIDTH`=9, 0x1FF -> `stp_err`=1, no `data_valid`. The next clean frame 0x055 clears `stp_err` and gives `data_valid`.
- Two back-to-back 8O1 frames 0x00 and 0xFF with no idle gap -> two `data_valid` pulses exactly 11×`Prescale` cycles apart.
- `UART_RX_BREAK_DET_EN` with `RX_IN` low for 3 frame times -> one `break_det` pulse, no `stp_err`, IDLE reached only after the line returns high. Reset asserted mid-DATA -> all outputs 0.
